// File: rtl/niosduino_pio_pkg.sv
// Package for the niosduino output PIO.
// Holds the register word offsets of the Avalon-MM register map and the
// helper that expands a 4-bit byteenable into a 32-bit per-bit lane mask.
package niosduino_pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
    localparam logic [2:0] PIO_ADDR_PORT     = 3'd1;
    localparam logic [2:0] PIO_ADDR_PULSE    = 3'd2;
    localparam logic [2:0] PIO_ADDR_PULSECNT = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR   = 3'd5;

    // Expand byte-lane enables into a bit mask (lane n covers bits 8n+7..8n).
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] mask_v;
        mask_v = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return mask_v;
    endfunction

endpackage

// File: rtl/niosduino_pio_pulse_timer.sv
// Pulse timer for the niosduino output PIO.
// Holds the pulse mask (bits currently inverted on out_port) and the
// down-counter of cycles remaining in the pulse.
// Ports:
//   clk        in   1             rising-edge clock
//   reset      in   1             synchronous active-high reset
//   load       in   1             launch/extend a pulse this cycle
//   load_mask  in   DATA_WIDTH    bits to add to the pulse mask on load
//   pulse_mask out  DATA_WIDTH    registered pulse mask
//   pulse_cnt  out  CNT_W         registered cycles remaining (0 = idle)
module niosduino_pio_pulse_timer #(
    parameter int DATA_WIDTH   = 32,
    parameter int PULSE_CYCLES = 16,
    parameter int CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_mask,
    output logic [DATA_WIDTH-1:0] pulse_mask,
    output logic [CNT_W-1:0]      pulse_cnt
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [DATA_WIDTH-1:0] mask_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  expiring_s;

    // Last cycle of the pulse: the mask drops on this edge.
    assign expiring_s = (cnt_r == CNT_ONE);

    // Counter and mask update. A load on the expiring edge starts from an
    // empty mask so the old bits do not survive into the new pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= {DATA_WIDTH{1'b0}};
            cnt_r  <= CNT_ZERO;
        end else if (load) begin
            mask_r <= (expiring_s ? {DATA_WIDTH{1'b0}} : mask_r) | load_mask;
            cnt_r  <= CNT_LOAD;
        end else begin
            if (expiring_s) begin
                mask_r <= {DATA_WIDTH{1'b0}};
            end else begin
                mask_r <= mask_r;
            end
            if (cnt_r != CNT_ZERO) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign pulse_mask = mask_r;
    assign pulse_cnt  = cnt_r;

endmodule

// File: rtl/niosduino_core_pio_out.sv
// Avalon-MM slave output PIO for the niosduino core.
// A data register drives out_port; OUTSET/OUTCLR give atomic bit set/clear;
// PULSE inverts chosen bits for PULSE_CYCLES cycles. out_port is
// data ^ pulse_mask, both registered.
// Optional build macro: PIO_OUT_BYTEENABLE_EN adds the byteenable port and
// restricts every write to the enabled byte lanes.
// Ports:
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous active-high reset
//   byteenable in   4            byte lanes (only with PIO_OUT_BYTEENABLE_EN)
//   address    in   3            register word address
//   chipselect in   1            slave select
//   write      in   1            write strobe, qualified by chipselect
//   writedata  in   32           write data
//   readdata   out  32           registered read data, 1-cycle latency
//   out_port   out  DATA_WIDTH   driven output
module niosduino_core_pio_out
    import niosduino_pio_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] RESET_VALUE  = 32'h0000_0000,
    parameter int          PULSE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef PIO_OUT_BYTEENABLE_EN
    input  logic [3:0]            byteenable,
`endif
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam int                    CNT_W    = $clog2(PULSE_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] DATA_RST = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_next_s;
    logic                  data_we_s;
    logic [31:0]           lanes_full_s;
    logic [DATA_WIDTH-1:0] lanes_s;
    logic [DATA_WIDTH-1:0] wd_s;
    logic [DATA_WIDTH-1:0] wd_lanes_s;
    logic                  wr_s;
    logic                  pulse_load_s;
    logic [DATA_WIDTH-1:0] pulse_mask_s;
    logic [CNT_W-1:0]      pulse_cnt_s;
    logic [31:0]           rd_next_s;
    logic [31:0]           readdata_r;

`ifdef PIO_OUT_BYTEENABLE_EN
    assign lanes_full_s = lane_mask(byteenable);
`else
    assign lanes_full_s = {32{1'b1}};
`endif

    // Write data above DATA_WIDTH is dropped; disabled lanes never touch state.
    assign lanes_s    = lanes_full_s[DATA_WIDTH-1:0];
    assign wd_s       = writedata[DATA_WIDTH-1:0];
    assign wd_lanes_s = wd_s & lanes_s;
    assign wr_s       = chipselect & write;

    // Write decode: next data value, data write enable and pulse launch.
    always_comb begin
        data_next_s  = data_r;
        data_we_s    = 1'b0;
        pulse_load_s = 1'b0;
        if (wr_s) begin
            case (address)
                PIO_ADDR_DATA: begin
                    data_next_s = (data_r & ~lanes_s) | wd_lanes_s;
                    data_we_s   = 1'b1;
                end
                PIO_ADDR_OUTSET: begin
                    data_next_s = data_r | wd_lanes_s;
                    data_we_s   = 1'b1;
                end
                PIO_ADDR_OUTCLR: begin
                    data_next_s = data_r & ~wd_lanes_s;
                    data_we_s   = 1'b1;
                end
                PIO_ADDR_PULSE: begin
                    // An all-zero pulse write must not restart the counter.
                    pulse_load_s = |wd_lanes_s;
                end
                default: begin
                    data_next_s  = data_r;
                    data_we_s    = 1'b0;
                    pulse_load_s = 1'b0;
                end
            endcase
        end else begin
            data_next_s  = data_r;
            data_we_s    = 1'b0;
            pulse_load_s = 1'b0;
        end
    end

    // Data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= DATA_RST;
        end else if (data_we_s) begin
            data_r <= data_next_s;
        end else begin
            data_r <= data_r;
        end
    end

    niosduino_pio_pulse_timer #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PULSE_CYCLES (PULSE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_pulse_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (pulse_load_s),
        .load_mask  (wd_lanes_s),
        .pulse_mask (pulse_mask_s),
        .pulse_cnt  (pulse_cnt_s)
    );

    // Both operands are registers, so out_port is glitch-free.
    assign out_port = data_r ^ pulse_mask_s;

    // Read mux; unused upper bits read as zero.
    always_comb begin
        rd_next_s = 32'h0000_0000;
        if (chipselect) begin
            case (address)
                PIO_ADDR_DATA:     rd_next_s[DATA_WIDTH-1:0] = data_r;
                PIO_ADDR_PORT:     rd_next_s[DATA_WIDTH-1:0] = out_port;
                PIO_ADDR_PULSE:    rd_next_s[DATA_WIDTH-1:0] = pulse_mask_s;
                PIO_ADDR_PULSECNT: rd_next_s[CNT_W-1:0]      = pulse_cnt_s;
                default:           rd_next_s = 32'h0000_0000;
            endcase
        end else begin
            rd_next_s = 32'h0000_0000;
        end
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'h0000_0000;
        end else begin
            readdata_r <= rd_next_s;
        end
    end

    assign readdata = readdata_r;

endmodule

// File: tb/tb_niosduino_core_pio_out.sv
// Directed self-checking bench for niosduino_core_pio_out with
// RESET_VALUE=0xA5, PULSE_CYCLES=16, DATA_WIDTH=32.
module tb_niosduino_core_pio_out;

    logic        clk;
    logic        reset;
    logic [3:0]  byteenable;
    logic [2:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;

    int pass_cnt  = 0;
    int total_cnt = 0;

    niosduino_core_pio_out #(
        .DATA_WIDTH   (32),
        .RESET_VALUE  (32'h0000_00A5),
        .PULSE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef PIO_OUT_BYTEENABLE_EN
        .byteenable (byteenable),
`endif
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; signals are then observed 1 time unit after the edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        chipselect = 1'b1;
        write      = 1'b1;
        tick(1);
        chipselect = 1'b0;
        write      = 1'b0;
        byteenable = 4'hF;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write      = 1'b0;
        tick(1);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] exp_be;

    initial begin
        reset      = 1'b1;
        byteenable = 4'hF;
        address    = 3'd0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        tick(2);

        // 1. Reset values
        check("rst_out_port", out_port, 32'h0000_00A5);
        check("rst_readdata", readdata, 32'h0000_0000);
        reset = 1'b0;
        bus_read(3'd0, rd);
        check("rst_data_read", rd, 32'h0000_00A5);

        // 2. DATA / OUTSET / OUTCLR
        bus_write(3'd0, 32'h0000_00F0, 4'hF);
        check("data_wr", out_port, 32'h0000_00F0);
        bus_write(3'd4, 32'h0000_000F, 4'hF);
        check("outset", out_port, 32'h0000_00FF);
        bus_write(3'd5, 32'h0000_0081, 4'hF);
        check("outclr", out_port, 32'h0000_007E);
        bus_read(3'd1, rd);
        check("port_read", rd, 32'h0000_007E);

        // Writes to 6/7 ignored, reads return 0; no read data without chipselect
        bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        check("addr6_wr_ignored", out_port, 32'h0000_007E);
        bus_read(3'd6, rd);
        check("addr6_read", rd, 32'h0000_0000);
        address = 3'd0;
        tick(1);
        check("no_cs_readdata", readdata, 32'h0000_0000);

        // 3. Pulse 0x3 for exactly 16 cycles
        bus_write(3'd0, 32'h0, 4'hF);
        bus_write(3'd2, 32'h0000_0000, 4'hF);
        bus_read(3'd3, rd);
        check("pulse_zero_noop", rd, 32'h0000_0000);
        bus_write(3'd2, 32'h0000_0003, 4'hF);
        for (int i = 16; i >= 1; i--) begin
            check($sformatf("pulse_out_%0d", i), out_port, 32'h0000_0003);
            bus_read(3'd3, rd);
            check($sformatf("pulsecnt_%0d", i), rd, 32'(i));
        end
        check("pulse_end", out_port, 32'h0000_0000);

        // 4a. Relaunch on the expiring cycle: old mask dropped
        bus_write(3'd2, 32'h0000_0001, 4'hF);
        tick(15);
        bus_write(3'd2, 32'h0000_0004, 4'hF);
        check("relaunch_exp_out", out_port, 32'h0000_0004);
        bus_read(3'd2, rd);
        check("relaunch_exp_mask", rd, 32'h0000_0004);
        tick(14);
        check("relaunch_exp_last", out_port, 32'h0000_0004);
        tick(1);
        check("relaunch_exp_end", out_port, 32'h0000_0000);

        // 4b. Relaunch mid-pulse: mask widened
        bus_write(3'd2, 32'h0000_0001, 4'hF);
        tick(8);
        bus_write(3'd2, 32'h0000_0004, 4'hF);
        check("relaunch_mid_out", out_port, 32'h0000_0005);
        bus_read(3'd2, rd);
        check("relaunch_mid_mask", rd, 32'h0000_0005);
        tick(14);
        check("relaunch_mid_last", out_port, 32'h0000_0005);
        tick(1);
        check("relaunch_mid_end", out_port, 32'h0000_0000);

        // Data change during a pulse keeps pulsed bits inverted
        bus_write(3'd2, 32'h0000_0001, 4'hF);
        bus_write(3'd0, 32'h0000_0055, 4'hF);
        check("data_during_pulse", out_port, 32'h0000_0054);

        // 5. Reset mid-pulse at cnt==5 (cnt now 15)
        tick(10);
        reset = 1'b1;
        tick(1);
        check("rst_mid_out", out_port, 32'h0000_00A5);
        check("rst_mid_readdata", readdata, 32'h0000_0000);
        reset = 1'b0;
        bus_read(3'd3, rd);
        check("rst_mid_cnt", rd, 32'h0000_0000);
        bus_read(3'd2, rd);
        check("rst_mid_mask", rd, 32'h0000_0000);

        // 6. Byte-lane write
        bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd0, 32'h0000_0000, 4'b0010);
`ifdef PIO_OUT_BYTEENABLE_EN
        exp_be = 32'hFFFF_00FF;
`else
        exp_be = 32'h0000_0000;
`endif
        bus_read(3'd0, rd);
        check("byteenable_data", rd, exp_be);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
